// File: rtl/gate_exhaustive_checker.sv
// Stimulus/response checker for the basic two-input gate set: sweeps a/b through
// all four combinations, holding each HOLD cycles, and grades the six gate outputs.
module gate_exhaustive_checker #(
    parameter int HOLD = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [1:0] vec,
    input  logic [5:0] dut_y,
    output logic       busy,
    output logic       done,
    output logic [2:0] err_count,
    output logic [5:0] err_mask,
    output logic       fail_valid,
    output logic [1:0] fail_vec
);

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    localparam logic [7:0] LAST_CNT = 8'(HOLD - 1);

    state_t     state;
    state_t     next_state;
    logic [7:0] hold_cnt;
    logic       window_end;
    logic       start_accept;
    logic [5:0] expected;
    logic [5:0] diff;

    // Golden response in dut_y bit order: {nand, xor, ~b, ~a, or, and}.
    function automatic logic [5:0] golden(input logic [1:0] v);
        logic a;
        logic b;
        a = v[1];
        b = v[0];
        return {~(a & b), a ^ b, ~b, ~a, a | b, a & b};
    endfunction

    assign window_end   = (state == DRIVE) && (hold_cnt == LAST_CNT);
    assign start_accept = start && (state != DRIVE);
    assign expected     = golden(vec);
    assign diff         = dut_y ^ expected;

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = DRIVE;
            DRIVE:   if (window_end && vec == 2'b11) next_state = DONE;
            DONE:    if (start) next_state = DRIVE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            DRIVE:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Only the last cycle of each window is graded, giving the gates HOLD-1 cycles to settle.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt   <= 8'd0;
            vec        <= 2'b00;
            err_count  <= 3'd0;
            err_mask   <= 6'd0;
            fail_valid <= 1'b0;
            fail_vec   <= 2'b00;
        end else if (start_accept) begin
            hold_cnt   <= 8'd0;
            vec        <= 2'b00;
            err_count  <= 3'd0;
            err_mask   <= 6'd0;
            fail_valid <= 1'b0;
            fail_vec   <= 2'b00;
        end else if (state == DRIVE) begin
            if (window_end) begin
                if (diff != 6'd0) begin
                    err_mask  <= err_mask | diff;
                    err_count <= err_count + 3'd1;
                    if (!fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_vec   <= vec;
                    end
                end
                hold_cnt <= 8'd0;
                if (vec != 2'b11)
                    vec <= vec + 2'd1;
            end else begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end
    end

endmodule
